// File: rtl/axis_bram_line_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// axis_bram_pkg
// Shared types for the AXI-Stream <-> wide-BRAM line sequencer:
//   - seq_state_e : sequencer FSM state encoding
//   - LANE_*      : 2-bit per-lane buffer mux codes
//   - state_is_busy() : busy decode used for the registered busy output
// ---------------------------------------------------------------------------
package axis_bram_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_FILL   = 3'd1,
    WR_COMMIT = 3'd2,
    RD_ISSUE  = 3'd3,
    RD_WAIT   = 3'd4,
    RD_DRAIN  = 3'd5,
    DONE      = 3'd6
  } seq_state_e;

  // Per-lane buffer mux codes
  localparam logic [1:0] LANE_HOLD   = 2'b00;
  localparam logic [1:0] LANE_BRAM   = 2'b10;
  localparam logic [1:0] LANE_STREAM = 2'b11;

  // Busy in every state except the two resting states
  function automatic logic state_is_busy(input seq_state_e s);
    logic b;
    case (s)
      IDLE, DONE: b = 1'b0;
      default:    b = 1'b1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/axis_bram_line_sequencer_lane_decoder.sv
// ---------------------------------------------------------------------------
// axis_bram_lane_decoder
// Combinational decode of the sequencer's lane request into per-lane buffer
// mux codes. Lane i occupies lane_cntl_o[2*i +: 2].
//   ptr_i           : lane pointer of the word currently being streamed in
//   load_stream_i   : write the stream word into lane ptr_i this cycle
//   load_all_bram_i : load every lane from BRAM_OUT this cycle
//   lane_cntl_o     : per-lane code (hold / load BRAM / load stream)
// ---------------------------------------------------------------------------
module axis_bram_lane_decoder
  import axis_bram_pkg::*;
#(
  parameter int WORDS_PER_LINE = 36,
  parameter int PTR_W          = 6
) (
  input  logic [PTR_W-1:0]            ptr_i,
  input  logic                        load_stream_i,
  input  logic                        load_all_bram_i,
  output logic [2*WORDS_PER_LINE-1:0] lane_cntl_o
);

  // Per-lane code; a BRAM line load overrides any stream write
  always_comb begin
    lane_cntl_o = {(2*WORDS_PER_LINE){1'b0}};
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      if (load_all_bram_i) begin
        lane_cntl_o[2*i +: 2] = LANE_BRAM;
      end else if (load_stream_i && (ptr_i == PTR_W'(i))) begin
        lane_cntl_o[2*i +: 2] = LANE_STREAM;
      end else begin
        lane_cntl_o[2*i +: 2] = LANE_HOLD;
      end
    end
  end

endmodule

// File: rtl/axis_bram_line_sequencer.sv
// ---------------------------------------------------------------------------
// axis_bram_line_sequencer
// Control sequencer for the AXI-Stream <-> wide-BRAM adapter.
//   Write mode : packs WORDS_PER_LINE stream words into the lane buffer, then
//                commits the line to BRAM; repeats for line_count lines.
//   Read mode  : reads a BRAM line into the lane buffer and serialises it out
//                word by word; repeats for line_count lines.
// Ports:
//   clk, rstn                       : clock, async active-low reset
//   rw, addr_reload, start_addr,
//   line_count                      : transfer configuration (sampled on reload)
//   stream_in_valid/stream_in_accep : slave stream handshake
//   stream_out_valid/_accep/_tlast  : master stream handshake
//   lane_cntl, out_sel              : lane buffer mux controls
//   bram_en, bram_wen, bram_addr    : BRAM port controls
//   busy                            : transfer in progress
// All outputs except lane_cntl are registered. lane_cntl is decoded from
// registered state plus stream_in_valid so a stream word lands in its lane in
// the same cycle it is accepted.
// ---------------------------------------------------------------------------
module axis_bram_line_sequencer
  import axis_bram_pkg::*;
#(
  parameter int BRAM_DEPTH     = 12,
  parameter int WORDS_PER_LINE = 36,
  parameter int PTR_W          = 6,
  parameter int RD_LAT         = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        rw,
  input  logic                        addr_reload,
  input  logic [BRAM_DEPTH-1:0]       start_addr,
  input  logic [BRAM_DEPTH-1:0]       line_count,
  input  logic                        stream_in_valid,
  output logic                        stream_in_accep,
  output logic                        stream_out_valid,
  input  logic                        stream_out_accep,
  output logic                        stream_out_tlast,
  output logic [2*WORDS_PER_LINE-1:0] lane_cntl,
  output logic [PTR_W-1:0]            out_sel,
  output logic                        bram_en,
  output logic                        bram_wen,
  output logic [BRAM_DEPTH-1:0]       bram_addr,
  output logic                        busy
);

  localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(WORDS_PER_LINE - 1);
  localparam logic [PTR_W-1:0]      PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
  localparam logic [BRAM_DEPTH-1:0] CNT_ZERO = {BRAM_DEPTH{1'b0}};
  localparam logic [BRAM_DEPTH-1:0] CNT_ONE  = BRAM_DEPTH'(1);
  // RD_WAIT occupies RD_LAT-1 cycles: load the counter with RD_LAT-2
  localparam logic [1:0]            WAIT_INIT = 2'(RD_LAT - 2);

  seq_state_e             state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [BRAM_DEPTH-1:0]  addr_q, addr_d;
  logic [BRAM_DEPTH-1:0]  rem_q, rem_d;
  logic [1:0]             wait_q, wait_d;
  // In RD_DRAIN: 0 on the cycle BRAM_OUT is being captured, 1 while draining
  logic                   loaded_q, loaded_d;

  logic                   in_accep_q, in_accep_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_tlast_q, out_tlast_d;
  logic [PTR_W-1:0]       out_sel_q, out_sel_d;
  logic                   bram_en_q, bram_en_d;
  logic                   bram_wen_q, bram_wen_d;
  logic [BRAM_DEPTH-1:0]  bram_addr_q, bram_addr_d;
  logic                   busy_q, busy_d;

  logic                   in_xfer_s;
  logic                   out_xfer_s;
  logic                   load_stream_s;
  logic                   load_all_bram_s;

  assign in_xfer_s  = in_accep_q & stream_in_valid;
  assign out_xfer_s = out_valid_q & stream_out_accep;

  // Next-state and datapath counters; addr_reload wins over every state
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    wait_d   = wait_q;
    loaded_d = loaded_q;
    if (addr_reload) begin
      addr_d   = start_addr;
      rem_d    = line_count;
      ptr_d    = PTR_ZERO;
      wait_d   = 2'd0;
      loaded_d = 1'b0;
      if (line_count == CNT_ZERO) begin
        state_d = DONE;
      end else if (rw) begin
        state_d = WR_FILL;
      end else begin
        state_d = RD_ISSUE;
      end
    end else begin
      case (state_q)
        WR_FILL: begin
          if (in_xfer_s) begin
            if (ptr_q == LAST_PTR) begin
              ptr_d   = PTR_ZERO;
              state_d = WR_COMMIT;
            end else begin
              ptr_d = ptr_q + PTR_ONE;
            end
          end else begin
            ptr_d = ptr_q;
          end
        end
        WR_COMMIT: begin
          addr_d = addr_q + CNT_ONE;
          rem_d  = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = DONE;
          end else begin
            state_d = WR_FILL;
          end
        end
        RD_ISSUE: begin
          loaded_d = 1'b0;
          if (RD_LAT == 1) begin
            state_d = RD_DRAIN;
          end else begin
            wait_d  = WAIT_INIT;
            state_d = RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (wait_q == 2'd0) begin
            state_d = RD_DRAIN;
          end else begin
            wait_d = wait_q - 2'd1;
          end
        end
        RD_DRAIN: begin
          if (!loaded_q) begin
            loaded_d = 1'b1;
          end else if (out_xfer_s) begin
            if (ptr_q == LAST_PTR) begin
              ptr_d    = PTR_ZERO;
              addr_d   = addr_q + CNT_ONE;
              rem_d    = rem_q - CNT_ONE;
              loaded_d = 1'b0;
              if (rem_q == CNT_ONE) begin
                state_d = DONE;
              end else begin
                state_d = RD_ISSUE;
              end
            end else begin
              ptr_d = ptr_q + PTR_ONE;
            end
          end else begin
            ptr_d = ptr_q;
          end
        end
        IDLE, DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output values for the next cycle, derived from the next state so they register glitch-free
  always_comb begin
    busy_d      = state_is_busy(state_d);
    in_accep_d  = (state_d == WR_FILL);
    out_valid_d = (state_d == RD_DRAIN) && loaded_d;
    if (out_valid_d) begin
      out_sel_d   = ptr_d;
      out_tlast_d = (ptr_d == LAST_PTR) && (rem_d == CNT_ONE);
    end else begin
      out_sel_d   = PTR_ZERO;
      out_tlast_d = 1'b0;
    end
    bram_en_d  = (state_d == WR_COMMIT) || (state_d == RD_ISSUE);
    bram_wen_d = (state_d == WR_COMMIT);
    if (bram_en_d) begin
      bram_addr_d = addr_d;
    end else begin
      bram_addr_d = CNT_ZERO;
    end
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ptr_q       <= PTR_ZERO;
      addr_q      <= CNT_ZERO;
      rem_q       <= CNT_ZERO;
      wait_q      <= 2'd0;
      loaded_q    <= 1'b0;
      in_accep_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_tlast_q <= 1'b0;
      out_sel_q   <= PTR_ZERO;
      bram_en_q   <= 1'b0;
      bram_wen_q  <= 1'b0;
      bram_addr_q <= CNT_ZERO;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      wait_q      <= wait_d;
      loaded_q    <= loaded_d;
      in_accep_q  <= in_accep_d;
      out_valid_q <= out_valid_d;
      out_tlast_q <= out_tlast_d;
      out_sel_q   <= out_sel_d;
      bram_en_q   <= bram_en_d;
      bram_wen_q  <= bram_wen_d;
      bram_addr_q <= bram_addr_d;
      busy_q      <= busy_d;
    end
  end

  // Stream word lands in lane ptr as it is accepted; first RD_DRAIN cycle captures BRAM_OUT
  assign load_stream_s   = (state_q == WR_FILL) & stream_in_valid;
  assign load_all_bram_s = (state_q == RD_DRAIN) & ~loaded_q;

  axis_bram_lane_decoder #(
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .PTR_W          (PTR_W)
  ) u_lane_decoder (
    .ptr_i           (ptr_q),
    .load_stream_i   (load_stream_s),
    .load_all_bram_i (load_all_bram_s),
    .lane_cntl_o     (lane_cntl)
  );

  assign stream_in_accep  = in_accep_q;
  assign stream_out_valid = out_valid_q;
  assign stream_out_tlast = out_tlast_q;
  assign out_sel          = out_sel_q;
  assign bram_en          = bram_en_q;
  assign bram_wen         = bram_wen_q;
  assign bram_addr        = bram_addr_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_axis_bram_line_sequencer.sv
// ---------------------------------------------------------------------------
// tb_axis_bram_line_sequencer
// Directed scenarios push the events they expect (lane writes, BRAM writes,
// BRAM reads, line loads, stream-out words) into a queue; a monitor process
// pops and compares whenever the DUT presents one of those events.
// ---------------------------------------------------------------------------
module tb_axis_bram_line_sequencer;

  localparam int BD  = 12;
  localparam int WPL = 4;
  localparam int PW  = 2;
  localparam int RL  = 2;

  localparam int EV_LANE = 0;
  localparam int EV_WR   = 1;
  localparam int EV_RD   = 2;
  localparam int EV_LOAD = 3;
  localparam int EV_OUT  = 4;

  typedef struct {
    int kind;
    int val;
  } exp_t;

  logic              clk = 1'b0;
  logic              rstn;
  logic              rw;
  logic              addr_reload;
  logic [BD-1:0]     start_addr;
  logic [BD-1:0]     line_count;
  logic              stream_in_valid;
  logic              stream_in_accep;
  logic              stream_out_valid;
  logic              stream_out_accep;
  logic              stream_out_tlast;
  logic [2*WPL-1:0]  lane_cntl;
  logic [PW-1:0]     out_sel;
  logic              bram_en;
  logic              bram_wen;
  logic [BD-1:0]     bram_addr;
  logic              busy;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rd_cyc = 0;
  int   in_xfers = 0;

  axis_bram_line_sequencer #(
    .BRAM_DEPTH     (BD),
    .WORDS_PER_LINE (WPL),
    .PTR_W          (PW),
    .RD_LAT         (RL)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .rw               (rw),
    .addr_reload      (addr_reload),
    .start_addr       (start_addr),
    .line_count       (line_count),
    .stream_in_valid  (stream_in_valid),
    .stream_in_accep  (stream_in_accep),
    .stream_out_valid (stream_out_valid),
    .stream_out_accep (stream_out_accep),
    .stream_out_tlast (stream_out_tlast),
    .lane_cntl        (lane_cntl),
    .out_sel          (out_sel),
    .bram_en          (bram_en),
    .bram_wen         (bram_wen),
    .bram_addr        (bram_addr),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  function automatic void push(input int k, input int v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  function automatic void push_line_fill();
    for (int i = 0; i < WPL; i++) push(EV_LANE, i);
  endfunction

  function automatic void push_line_drain(input bit last_line);
    for (int i = 0; i < WPL; i++)
      push(EV_OUT, ((last_line && i == WPL - 1) ? 100 : 0) + i);
  endfunction

  task automatic expect_ev(input int k, input int v);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d val %0d required none", k, v);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", k, e.kind);
      chk("event_val", v, e.val);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge
  initial begin
    int n10, n11, nbad, idx;
    logic [1:0] code;
    forever begin
      @(negedge clk);
      cyc++;
      if (rstn) begin
        if (bram_en) begin
          if (bram_wen) begin
            expect_ev(EV_WR, int'(bram_addr));
          end else begin
            expect_ev(EV_RD, int'(bram_addr));
            rd_cyc = cyc;
          end
        end
        if (lane_cntl != 8'h00) begin
          n10 = 0; n11 = 0; nbad = 0; idx = 0;
          for (int i = 0; i < WPL; i++) begin
            code = lane_cntl[2*i +: 2];
            if (code == 2'b10) n10++;
            else if (code == 2'b11) begin n11++; idx = i; end
            else if (code == 2'b01) nbad++;
          end
          if (n10 == WPL) begin
            expect_ev(EV_LOAD, 0);
            chk("load_latency", cyc - rd_cyc, RL);
          end else if (n11 == 1 && n10 == 0 && nbad == 0) begin
            expect_ev(EV_LANE, idx);
          end else begin
            chk("lane_pattern", int'(lane_cntl), 0);
          end
        end
        if (stream_in_valid && stream_in_accep) in_xfers++;
        if (stream_out_valid && stream_out_accep)
          expect_ev(EV_OUT, int'(stream_out_tlast) * 100 + int'(out_sel));
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required test end");
    $fatal(1, "watchdog expired");
  end

  task automatic reload(input logic r, input int sa, input int lc);
    rw          = r;
    start_addr  = BD'(sa);
    line_count  = BD'(lc);
    addr_reload = 1'b1;
    @(posedge clk); #1;
    addr_reload = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int ok;
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    chk(name, ok, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt;
    int exp_ptr;
    int k;
    bit stall_prev;
    logic [3:0] pat;

    rstn = 1'b0; rw = 1'b0; addr_reload = 1'b0; start_addr = '0; line_count = '0;
    stream_in_valid = 1'b0; stream_out_accep = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_busy", int'(busy), 0);
    chk("rst_bram_en", int'(bram_en), 0);
    chk("rst_in_accep", int'(stream_in_accep), 0);
    chk("rst_out_valid", int'(stream_out_valid), 0);
    chk("rst_lane_cntl", int'(lane_cntl), 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // 1: write two lines at 5,6; ten busy cycles
    push_line_fill(); push(EV_WR, 5);
    push_line_fill(); push(EV_WR, 6);
    in_xfers = 0;
    stream_in_valid = 1'b1;
    reload(1'b1, 5, 2);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else break;
    end
    chk("wr_busy_cycles", cnt, 10);
    @(posedge clk); #1;
    stream_in_valid = 1'b0;
    chk("wr_words", in_xfers, 8);

    // 2: read two lines at 7,8 with accept always high
    push(EV_RD, 7); push(EV_LOAD, 0); push_line_drain(1'b0);
    push(EV_RD, 8); push(EV_LOAD, 0); push_line_drain(1'b1);
    stream_out_accep = 1'b1;
    reload(1'b0, 7, 2);
    wait_idle("rd_done", 60);

    // 3: read one line with accept toggling 1,0,0,1
    push(EV_RD, 20); push(EV_LOAD, 0); push_line_drain(1'b1);
    pat = 4'b1001;
    stream_out_accep = 1'b0;
    reload(1'b0, 20, 1);
    exp_ptr = 0; k = 0; stall_prev = 1'b0;
    for (int i = 0; i < 80; i++) begin
      stream_out_accep = pat[k % 4];
      k++;
      @(negedge clk);
      if (stall_prev) chk("stall_valid_held", int'(stream_out_valid), 1);
      if (stream_out_valid) chk("stall_out_sel", int'(out_sel), exp_ptr);
      if (stream_out_valid && stream_out_accep) exp_ptr++;
      stall_prev = stream_out_valid && !stream_out_accep;
      if (!busy && i > 2) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    stream_out_accep = 1'b0;
    chk("stall_words", exp_ptr, WPL);

    // 4: write across the address wrap
    push_line_fill(); push(EV_WR, 4095);
    push_line_fill(); push(EV_WR, 0);
    in_xfers = 0;
    stream_in_valid = 1'b1;
    reload(1'b1, 4095, 2);
    wait_idle("wrap_done", 40);
    stream_in_valid = 1'b0;
    chk("wrap_words", in_xfers, 8);

    // 5: abort mid-fill, restart at a new address; then zero-line reload
    push(EV_LANE, 0); push(EV_LANE, 1);
    in_xfers = 0;
    stream_in_valid = 1'b1;
    reload(1'b1, 100, 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    stream_in_valid = 1'b0;
    push_line_fill(); push(EV_WR, 200);
    reload(1'b1, 200, 1);
    stream_in_valid = 1'b1;
    wait_idle("abort_done", 40);
    stream_in_valid = 1'b0;
    chk("abort_words", in_xfers, 6);
    reload(1'b0, 50, 0);
    @(negedge clk);
    chk("lc0_busy", int'(busy), 0);
    chk("lc0_bram_en", int'(bram_en), 0);
    repeat (3) @(posedge clk);
    #1;

    // 6: async reset while stalled in RD_DRAIN
    push(EV_RD, 30); push(EV_LOAD, 0);
    stream_out_accep = 1'b0;
    reload(1'b0, 30, 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stream_out_valid) begin
        cnt = 1;
        break;
      end
    end
    chk("drain_reached", cnt, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_out_valid", int'(stream_out_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_lane_cntl", int'(lane_cntl), 0);
    chk("arst_bram_en", int'(bram_en), 0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_valid", int'(stream_out_valid), 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
